// File: rtl/cpu_dynamic_branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB of 2-bit saturating counters with static BTFN fallback on a miss.
// Latency: prediction is combinational (zero cycles); an update is written at the sampling edge and is visible next cycle.
// Backpressure: none; a lookup is served every cycle and an update is accepted on every edge with i_upd_valid.
//
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_cond_branch, i_branch_instr,
//   i_jalr_instr, i_imm, i_pc            decode-side lookup request
//   o_predicted_pc, o_predicted_taken,
//   o_btb_hit                            combinational prediction
//   i_upd_*                              resolved-branch training port from execute
//   i_flush                              invalidate the whole table in one edge
//   o_mispred_cnt                        saturating misprediction counter
module cpu_dynamic_branch_predictor #(
  parameter int         BTB_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cond_branch,
  input  logic        i_branch_instr,
  input  logic        i_jalr_instr,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_pc,
  output logic [31:0] o_predicted_pc,
  output logic        o_predicted_taken,
  output logic        o_btb_hit,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_cond,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_mispredict,
  input  logic        i_flush,
  output logic [31:0] o_mispred_cnt
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = 30 - IDX_W;

  logic             btb_valid  [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
  logic [31:0]      btb_target [BTB_DEPTH];
  logic [1:0]       btb_ctr    [BTB_DEPTH];

  logic [31:0]      mispred_cnt_q;

  // Instructions are word aligned, so the two low PC bits never index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{i_pc[1:0], i_upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [31:0]      pc_plus4;
  logic [31:0]      pc_plus_imm;

  assign rd_idx      = i_pc[IDX_W+1:2];
  assign rd_tag      = i_pc[31:IDX_W+2];
  assign rd_hit      = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign pc_plus4    = i_pc + 32'd4;
  assign pc_plus_imm = i_pc + i_imm;

  always_comb begin
    o_predicted_pc    = pc_plus4;
    o_predicted_taken = 1'b0;
    if (i_branch_instr) begin
      if (!i_cond_branch && !i_jalr_instr) begin
        // jal: target is fully known at decode, the table adds nothing
        o_predicted_pc    = pc_plus_imm;
        o_predicted_taken = 1'b1;
      end else if (i_jalr_instr) begin
        // jalr target is register-dependent; only a trained entry can supply it
        if (rd_hit) begin
          o_predicted_pc    = btb_target[rd_idx];
          o_predicted_taken = 1'b1;
        end
      end else if (rd_hit) begin
        if (btb_ctr[rd_idx][1]) begin
          o_predicted_pc    = btb_target[rd_idx];
          o_predicted_taken = 1'b1;
        end
      end else if (i_imm[31]) begin
        // untrained conditional: backward taken, forward not taken
        o_predicted_pc    = pc_plus_imm;
        o_predicted_taken = 1'b1;
      end
    end
  end

  assign o_btb_hit = i_branch_instr && rd_hit;

  // ---------------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;

  assign wr_idx = i_upd_pc[IDX_W+1:2];
  assign wr_tag = i_upd_pc[31:IDX_W+2];
  assign wr_hit = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= CNT_INIT;
      end
    end else if (i_flush) begin
      // flush wins over a same-cycle update; tags/targets left as-is
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= CNT_INIT;
      end
    end else if (i_upd_valid) begin
      if (wr_hit) begin
        if (i_upd_cond) begin
          if (i_upd_taken) begin
            btb_target[wr_idx] <= i_upd_target;
            if (btb_ctr[wr_idx] != 2'b11) btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'd1;
          end else if (btb_ctr[wr_idx] != 2'b00) begin
            btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'd1;
          end
        end else begin
          btb_target[wr_idx] <= i_upd_target;
          btb_ctr[wr_idx]    <= 2'b11;
        end
      end else if (i_upd_taken) begin
        // allocate over whatever occupied the slot
        btb_valid[wr_idx]  <= 1'b1;
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= i_upd_target;
        btb_ctr[wr_idx]    <= i_upd_cond ? 2'b10 : 2'b11;
      end
    end
  end

  // Counted independently of flush so a dropped update still registers its mispredict.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mispred_cnt_q <= '0;
    end else if (i_upd_valid && i_upd_mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_cpu_dynamic_branch_predictor.sv
module tb_cpu_dynamic_branch_predictor;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_cond_branch;
  logic        i_branch_instr;
  logic        i_jalr_instr;
  logic [31:0] i_imm;
  logic [31:0] i_pc;
  logic [31:0] o_predicted_pc;
  logic        o_predicted_taken;
  logic        o_btb_hit;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_cond;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_mispredict;
  logic        i_flush;
  logic [31:0] o_mispred_cnt;

  int errors = 0;
  int checks = 0;

  cpu_dynamic_branch_predictor #(.BTB_DEPTH(64), .CNT_INIT(2'b01)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cond_branch(i_cond_branch), .i_branch_instr(i_branch_instr),
    .i_jalr_instr(i_jalr_instr), .i_imm(i_imm), .i_pc(i_pc),
    .o_predicted_pc(o_predicted_pc), .o_predicted_taken(o_predicted_taken),
    .o_btb_hit(o_btb_hit),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_cond(i_upd_cond),
    .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target),
    .i_upd_mispredict(i_upd_mispredict), .i_flush(i_flush),
    .o_mispred_cnt(o_mispred_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------------------------------------------------------------------
  // Reference model: table keyed by word-address slot, counter as plain int
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          v;
    bit [31:0]   tag;
    bit [31:0]   tgt;
    int          ctr;
  } ent_t;

  ent_t    m_tab [64];
  longint  m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_tab[i].v = 0; m_tab[i].tag = 0; m_tab[i].tgt = 0; m_tab[i].ctr = 1;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_predict(input bit [31:0] pc, input bit br, input bit cond,
                                        input bit jalr, input bit [31:0] imm,
                                        output bit [31:0] ppc, output bit tk, output bit ht);
    int unsigned idx = (pc / 4) % 64;
    bit hit = m_tab[idx].v && (m_tab[idx].tag == pc / 256);
    ht = br && hit;
    ppc = pc + 4; tk = 0;
    if (br) begin
      if (!cond && !jalr) begin ppc = pc + imm; tk = 1; end
      else if (jalr) begin if (hit) begin ppc = m_tab[idx].tgt; tk = 1; end end
      else if (hit) begin if (m_tab[idx].ctr >= 2) begin ppc = m_tab[idx].tgt; tk = 1; end end
      else if ($signed(imm) < 0) begin ppc = pc + imm; tk = 1; end
    end
  endfunction

  function automatic void model_update(input bit vld, input bit [31:0] pc, input bit cond,
                                       input bit taken, input bit [31:0] tgt,
                                       input bit mis, input bit flush);
    int unsigned idx = (pc / 4) % 64;
    bit hit = m_tab[idx].v && (m_tab[idx].tag == pc / 256);
    if (vld && mis && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (flush) begin
      for (int i = 0; i < 64; i++) begin m_tab[i].v = 0; m_tab[i].ctr = 1; end
    end else if (vld) begin
      if (hit && cond) begin
        m_tab[idx].ctr = taken ? ((m_tab[idx].ctr == 3) ? 3 : m_tab[idx].ctr + 1)
                               : ((m_tab[idx].ctr == 0) ? 0 : m_tab[idx].ctr - 1);
        if (taken) m_tab[idx].tgt = tgt;
      end else if (hit) begin
        m_tab[idx].tgt = tgt; m_tab[idx].ctr = 3;
      end else if (taken) begin
        m_tab[idx].v = 1; m_tab[idx].tag = pc / 256; m_tab[idx].tgt = tgt;
        m_tab[idx].ctr = cond ? 2 : 3;
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive only; comparisons live in the test tasks)
  // ---------------------------------------------------------------------------
  task automatic set_lookup(input bit [31:0] pc, input bit br, input bit cond,
                            input bit jalr, input bit [31:0] imm);
    i_pc = pc; i_branch_instr = br; i_cond_branch = cond; i_jalr_instr = jalr; i_imm = imm;
    #1;
  endtask

  // Called at a negedge; returns at the following negedge with the update applied.
  task automatic apply_update(input bit [31:0] pc, input bit cond, input bit taken,
                              input bit [31:0] tgt, input bit mis, input bit flush);
    i_upd_valid = 1'b1; i_upd_pc = pc; i_upd_cond = cond; i_upd_taken = taken;
    i_upd_target = tgt; i_upd_mispredict = mis; i_flush = flush;
    @(posedge i_clk);
    model_update(1'b1, pc, cond, taken, tgt, mis, flush);
    @(negedge i_clk);
    i_upd_valid = 1'b0; i_flush = 1'b0; i_upd_mispredict = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    set_lookup(32'h100, 1, 1, 0, -32'sd16);
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit, o_mispred_cnt} !== {32'hF0, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_static got pc=%h tk=%b hit=%b cnt=%h exp pc=000000f0 tk=1 hit=0 cnt=0",
               o_predicted_pc, o_predicted_taken, o_btb_hit, o_mispred_cnt);
    end
  endtask

  task automatic test_static();
    set_lookup(32'h100, 1, 1, 0, -32'sd16);
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit} !== {32'hF0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL static_backward got pc=%h tk=%b hit=%b exp pc=000000f0 tk=1 hit=0",
               o_predicted_pc, o_predicted_taken, o_btb_hit);
    end
    set_lookup(32'h100, 1, 1, 0, 32'd16);
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit} !== {32'h104, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL static_forward got pc=%h tk=%b hit=%b exp pc=00000104 tk=0 hit=0",
               o_predicted_pc, o_predicted_taken, o_btb_hit);
    end
    set_lookup(32'h100, 0, 0, 0, -32'sd16);
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit} !== {32'h104, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL non_branch got pc=%h tk=%b hit=%b exp pc=00000104 tk=0 hit=0",
               o_predicted_pc, o_predicted_taken, o_btb_hit);
    end
  endtask

  task automatic test_training();
    set_lookup(32'h200, 1, 1, 0, 32'd8);
    apply_update(32'h200, 1, 1, 32'h180, 0, 0);      // allocate, ctr=10
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit} !== {32'h180, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL train_alloc got pc=%h tk=%b hit=%b exp pc=00000180 tk=1 hit=1",
               o_predicted_pc, o_predicted_taken, o_btb_hit);
    end
    apply_update(32'h200, 1, 0, 32'h0, 1, 0);        // 01
    apply_update(32'h200, 1, 0, 32'h0, 1, 0);        // 00
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit} !== {32'h204, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL train_not_taken got pc=%h tk=%b hit=%b exp pc=00000204 tk=0 hit=1",
               o_predicted_pc, o_predicted_taken, o_btb_hit);
    end
    for (int i = 0; i < 4; i++) apply_update(32'h200, 1, 1, 32'h180, 0, 0);  // 01,10,11,11
    checks++;
    if ({o_predicted_pc, o_predicted_taken} !== {32'h180, 1'b1}) begin
      errors++;
      $display("FAIL train_saturate_hi got pc=%h tk=%b exp pc=00000180 tk=1",
               o_predicted_pc, o_predicted_taken);
    end
    apply_update(32'h200, 1, 0, 32'h0, 0, 0);        // 10 if saturated, still taken
    checks++;
    if ({o_predicted_pc, o_predicted_taken} !== {32'h180, 1'b1}) begin
      errors++;
      $display("FAIL train_after_sat got pc=%h tk=%b exp pc=00000180 tk=1",
               o_predicted_pc, o_predicted_taken);
    end
    checks++;
    if (o_mispred_cnt !== 32'd2) begin
      errors++;
      $display("FAIL mispred_count got=%h exp=00000002", o_mispred_cnt);
    end
  endtask

  task automatic test_jalr_jal();
    set_lookup(32'h300, 1, 0, 1, 32'h0);
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit} !== {32'h304, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL jalr_untrained got pc=%h tk=%b hit=%b exp pc=00000304 tk=0 hit=0",
               o_predicted_pc, o_predicted_taken, o_btb_hit);
    end
    apply_update(32'h300, 0, 1, 32'h1000, 0, 0);
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit} !== {32'h1000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL jalr_trained got pc=%h tk=%b hit=%b exp pc=00001000 tk=1 hit=1",
               o_predicted_pc, o_predicted_taken, o_btb_hit);
    end
    set_lookup(32'hFFFF_FFFC, 1, 0, 0, 32'd8);
    checks++;
    if ({o_predicted_pc, o_predicted_taken} !== {32'h4, 1'b1}) begin
      errors++;
      $display("FAIL jal_wrap got pc=%h tk=%b exp pc=00000004 tk=1", o_predicted_pc, o_predicted_taken);
    end
  endtask

  task automatic test_alias();
    // 0x300 already displaced 0x200 in the shared slot; verify both views
    set_lookup(32'h300, 1, 0, 1, 32'h0);
    checks++;
    if ({o_predicted_pc, o_btb_hit} !== {32'h1000, 1'b1}) begin
      errors++;
      $display("FAIL alias_new_hit got pc=%h hit=%b exp pc=00001000 hit=1", o_predicted_pc, o_btb_hit);
    end
    set_lookup(32'h200, 1, 1, 0, 32'd8);
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit} !== {32'h204, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL alias_old_miss got pc=%h tk=%b hit=%b exp pc=00000204 tk=0 hit=0",
               o_predicted_pc, o_predicted_taken, o_btb_hit);
    end
  endtask

  task automatic test_flush();
    bit [31:0] exp_cnt;
    apply_update(32'h400, 1, 1, 32'h500, 0, 0);
    set_lookup(32'h400, 1, 1, 0, 32'd8);
    checks++;
    if ({o_predicted_pc, o_btb_hit} !== {32'h500, 1'b1}) begin
      errors++;
      $display("FAIL flush_pretrain got pc=%h hit=%b exp pc=00000500 hit=1", o_predicted_pc, o_btb_hit);
    end
    exp_cnt = 32'(m_cnt + 1);
    apply_update(32'h400, 1, 1, 32'h600, 1, 1);
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit} !== {32'h404, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL flush_drops_update got pc=%h tk=%b hit=%b exp pc=00000404 tk=0 hit=0",
               o_predicted_pc, o_predicted_taken, o_btb_hit);
    end
    checks++;
    if (o_mispred_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL flush_mispred_cnt got=%h exp=%h", o_mispred_cnt, exp_cnt);
    end
    set_lookup(32'h300, 1, 0, 1, 32'h0);
    checks++;
    if (o_btb_hit !== 1'b0) begin
      errors++;
      $display("FAIL flush_other_entry got hit=%b exp hit=0", o_btb_hit);
    end
  endtask

  task automatic test_back_to_back();
    apply_update(32'h2A8, 1, 1, 32'h2000, 0, 0);     // 10
    for (int i = 0; i < 3; i++) apply_update(32'h2A8, 1, 0, 32'h0, 0, 0);  // 01,00,00
    set_lookup(32'h2A8, 1, 1, 0, -32'sd4);
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit} !== {32'h2AC, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_floor got pc=%h tk=%b hit=%b exp pc=000002ac tk=0 hit=1",
               o_predicted_pc, o_predicted_taken, o_btb_hit);
    end
    apply_update(32'h2A8, 1, 1, 32'h2400, 0, 0);     // 01: still not taken
    checks++;
    if (o_predicted_taken !== 1'b0) begin
      errors++;
      $display("FAIL b2b_step1 got tk=%b exp tk=0", o_predicted_taken);
    end
    apply_update(32'h2A8, 1, 1, 32'h2400, 0, 0);     // 10: taken, newest target
    checks++;
    if ({o_predicted_pc, o_predicted_taken} !== {32'h2400, 1'b1}) begin
      errors++;
      $display("FAIL b2b_step2 got pc=%h tk=%b exp pc=00002400 tk=1", o_predicted_pc, o_predicted_taken);
    end
  endtask

  task automatic test_random();
    bit [31:0] epc;
    bit        etk, eht;
    int        kind;
    bit [31:0] upc;
    bit        ucond, utaken, umis, uvld, uflush;
    bit [31:0] utgt;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 3);
      i_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
      i_branch_instr = (kind != 0);
      i_cond_branch  = (kind == 3);
      i_jalr_instr   = (kind == 2);
      i_imm = $urandom_range(0, 1) ? -($urandom_range(1, 64) * 4) : ($urandom_range(0, 64) * 4);
      uvld   = $urandom_range(0, 1);
      upc    = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
      ucond  = $urandom_range(0, 1);
      utaken = $urandom_range(0, 1);
      umis   = $urandom_range(0, 1);
      utgt   = $urandom & 32'hFFFF_FFFC;
      uflush = ($urandom_range(0, 39) == 0);
      i_upd_valid = uvld; i_upd_pc = upc; i_upd_cond = ucond; i_upd_taken = utaken;
      i_upd_target = utgt; i_upd_mispredict = umis; i_flush = uflush;
      #1;
      model_predict(i_pc, i_branch_instr, i_cond_branch, i_jalr_instr, i_imm, epc, etk, eht);
      checks++;
      if ({o_predicted_pc, o_predicted_taken, o_btb_hit} !== {epc, etk, eht}) begin
        errors++;
        $display("FAIL random_pred n=%0d pc=%h got pc=%h tk=%b hit=%b exp pc=%h tk=%b hit=%b",
                 n, i_pc, o_predicted_pc, o_predicted_taken, o_btb_hit, epc, etk, eht);
      end
      checks++;
      if (o_mispred_cnt !== 32'(m_cnt)) begin
        errors++;
        $display("FAIL random_cnt n=%0d got=%h exp=%h", n, o_mispred_cnt, 32'(m_cnt));
      end
      @(posedge i_clk);
      model_update(uvld, upc, ucond, utaken, utgt, umis, uflush);
      @(negedge i_clk);
    end
    i_upd_valid = 1'b0; i_flush = 1'b0; i_upd_mispredict = 1'b0;
  endtask

  task automatic test_mispred_sat();
    force dut.mispred_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispred_cnt_q;
    m_cnt = 64'hFFFF_FFFE;
    apply_update(32'h7F0, 1, 0, 32'h0, 1, 0);
    checks++;
    if (o_mispred_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mispred_reach_max got=%h exp=ffffffff", o_mispred_cnt);
    end
    apply_update(32'h7F0, 1, 0, 32'h0, 1, 0);
    apply_update(32'h7F0, 1, 0, 32'h0, 1, 0);
    checks++;
    if (o_mispred_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mispred_saturate got=%h exp=ffffffff", o_mispred_cnt);
    end
  endtask

  task automatic test_async_reset();
    apply_update(32'h200, 1, 1, 32'h180, 1, 0);
    set_lookup(32'h200, 1, 1, 0, 32'd8);
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({o_predicted_pc, o_predicted_taken, o_btb_hit, o_mispred_cnt} !== {32'h204, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL async_reset got pc=%h tk=%b hit=%b cnt=%h exp pc=00000204 tk=0 hit=0 cnt=0",
               o_predicted_pc, o_predicted_taken, o_btb_hit, o_mispred_cnt);
    end
    // updates presented during reset must not land
    i_upd_valid = 1'b1; i_upd_pc = 32'h200; i_upd_cond = 1'b1; i_upd_taken = 1'b1;
    i_upd_target = 32'h180; i_upd_mispredict = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_upd_valid = 1'b0; i_upd_mispredict = 1'b0;
    i_rst_n = 1'b1;
    #1;
    checks++;
    if ({o_btb_hit, o_mispred_cnt} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_held got hit=%b cnt=%h exp hit=0 cnt=0", o_btb_hit, o_mispred_cnt);
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_cond_branch = 0; i_branch_instr = 0; i_jalr_instr = 0; i_imm = 0; i_pc = 0;
    i_upd_valid = 0; i_upd_pc = 0; i_upd_cond = 0; i_upd_taken = 0; i_upd_target = 0;
    i_upd_mispredict = 0; i_flush = 0;
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    test_reset();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    test_static();
    test_training();
    test_jalr_jal();
    test_alias();
    test_flush();
    test_back_to_back();
    test_random();
    test_mispred_sat();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
